wb_arbiter2: RTL and testbench
==============================

// Module: wb_arbiter2
// PURPOSE
//  Two-master, one-slave bus arbiter in front of the shared memory/peripheral bus.
//  Master 0 is the CPU; master 1 is a secondary master (DMA or video fetch).
//  Requests are granted round-robin and locked until ack or timeout.
//  A stale strobe held after ack is ignored; the CPU keeps stb_o high one cycle after ack_i.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width (byte selects = DW/8)
//  TIMEOUT  255  cycles without s_ack before the transfer is aborted; 0 disables the timeout
// PORTS
//  clk       in   1      system clock
//  rst_ni    in   1      asynchronous active-low reset
//  m0_stb    in   1      master 0 request/strobe
//  m0_we     in   1      master 0 write enable
//  m0_adr    in   AW     master 0 address
//  m0_dat    in   DW     master 0 write data
//  m0_sel    in   DW/8   master 0 byte selects
//  m0_ack    out  1      master 0 acknowledge
//  m0_err    out  1      master 0 timeout abort (1-cycle pulse)
//  m1_*      -    -      same set as m0_* for master 1
//  m_dat     out  DW     read data, s_dat_i broadcast to both masters
//  s_stb, s_we, s_adr, s_dat, s_sel   out   slave-side bus, registered
//  s_dat_i   in   DW     slave read data
//  s_ack     in   1      slave acknowledge
//  gnt       out  1      index of the current/last granted master (debug)
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset values: s_stb=0, s_we=0, s_adr=0, s_dat=0, s_sel=0, gnt=0, m*_ack=0, m*_err=0,
//   prio=0 (master 0 preferred), stale mask=00, timeout counter=0, state=IDLE.
//  Request: req[i] = m{i}_stb & ~stale[i].
//  stale[i] is set on completion (ack or err) of master i's transfer.
//   It clears on the first cycle m{i}_stb is sampled low.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE:
//   - No req: stay in IDLE; s_stb=0.
//   - One req: grant it.
//   - Both req: grant master prio.
//   - On grant: register gnt and copy that master's we/adr/dat/sel into s_*; s_stb<=1;
//     counter<=0; go to BUSY.
//   - Latency: first s_stb high 1 cycle after m_stb rises.
//  BUSY:
//   - s_* held constant; granted master's signals are not re-sampled.
//   - m{gnt}_ack = s_ack, combinational, same cycle; the other master's ack is 0.
//   - On s_ack: s_stb<=0, stale[gnt]<=1, prio<=~gnt, go to DONE.
//   - Else counter++. If TIMEOUT!=0 and counter==TIMEOUT-1: pulse m{gnt}_err for 1 cycle,
//     s_stb<=0, stale[gnt]<=1, prio<=~gnt, go to DONE.
//   - s_ack arriving in the same cycle as the timeout: ack wins; no err is raised.
//  DONE: one idle cycle on the slave bus (s_stb=0); go to IDLE. Requests are not granted here.
//  Any s_ack outside BUSY is ignored and never forwarded to a master.
//  m_dat = s_dat_i at all times; valid only in the m*_ack cycle.
//  Counter width: clog2(TIMEOUT+1); it saturates and never wraps.
//  Reset asserted mid-transfer: all outputs return to reset values immediately (async);
//   the transfer is dropped with no ack and no err.
//  Master dropping stb during BUSY: the transfer still completes on the slave side;
//   ack goes to that master anyway; stale then clears because stb is already low.
//  Back-to-back transfers from a single master: at most one transfer per 4 cycles
//   (IDLE, BUSY, DONE, stale-clear).
// TESTING
//  T1: m0 read adr=0x100, slave acks 2 cycles after s_stb -> s_adr=0x100; m0_ack is 1 for 1 cycle;
//      m_dat=0xDEADBEEF; m0 stb held 1 extra cycle -> no second s_stb.
//  T2: m0 and m1 raise stb in the same cycle, three times -> grant order m0, m1, m0 (round-robin).
//  T3: m1 write adr=0x200 dat=0x12345678 sel=4'b0011 while m0 stb is held high
//      -> s_* carries m1's values unchanged until s_ack; m0 is granted afterwards.
//  T4: TIMEOUT=4, slave never acks -> m0_err pulses in the 4th BUSY cycle; s_stb drops;
//      m1 is then served.
//  T5: s_ack and timeout coincide (ack in the 4th cycle) -> m0_ack=1, m0_err=0.
//  T6: rst_ni pulled low mid-BUSY -> s_stb=0 asynchronously; no ack or err;
//      after release, IDLE with prio=0.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone-style arbiter: round-robin grant, locked until
// slave ack or timeout, with a one-cycle idle slot on the slave bus between transfers.
module wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_ni,

    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat,
    input  logic [DW/8-1:0] m0_sel,
    output logic            m0_ack,
    output logic            m0_err,

    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat,
    input  logic [DW/8-1:0] m1_sel,
    output logic            m1_ack,
    output logic            m1_err,

    output logic [DW-1:0]   m_dat,

    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat,
    output logic [DW/8-1:0] s_sel,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack,

    output logic            gnt
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_TC  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    // state   | meaning
    // IDLE    | arbitrate between live requests, no slave cycle
    // BUSY    | slave cycle in flight for master gnt_q
    // DONE    | one dead cycle on the slave bus before re-arbitration
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic              gnt_q;
    logic              prio_q;
    logic [1:0]        stale_q;
    logic [CW-1:0]     cnt_q;
    logic              s_stb_q;
    logic              s_we_q;
    logic [AW-1:0]     s_adr_q;
    logic [DW-1:0]     s_dat_q;
    logic [DW/8-1:0]   s_sel_q;

    logic [1:0]        req;
    logic              pick;
    logic              busy;
    logic              tmo_hit;
    logic              tmo_fire;
    logic              xfer_end;

    assign req      = {m1_stb & ~stale_q[1], m0_stb & ~stale_q[0]};
    assign pick     = (req == 2'b11) ? prio_q : req[1];
    assign busy     = (state_q == ST_BUSY);
    assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == CNT_TC);
    // ack has precedence over a timeout landing in the same cycle
    assign tmo_fire = busy & tmo_hit & ~s_ack;
    assign xfer_end = busy & (s_ack | tmo_hit);

    assign m0_ack = busy & ~gnt_q & s_ack;
    assign m1_ack = busy &  gnt_q & s_ack;
    assign m0_err = tmo_fire & ~gnt_q;
    assign m1_err = tmo_fire &  gnt_q;

    assign m_dat  = s_dat_i;
    assign s_stb  = s_stb_q;
    assign s_we   = s_we_q;
    assign s_adr  = s_adr_q;
    assign s_dat  = s_dat_q;
    assign s_sel  = s_sel_q;
    assign gnt    = gnt_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
            stale_q <= 2'b00;
            cnt_q   <= '0;
            s_stb_q <= 1'b0;
            s_we_q  <= 1'b0;
            s_adr_q <= '0;
            s_dat_q <= '0;
            s_sel_q <= '0;
        end else begin
            // a completed master stays masked until its strobe is seen low
            stale_q <= stale_q & {m1_stb, m0_stb};
            case (state_q)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        gnt_q   <= pick;
                        s_we_q  <= pick ? m1_we  : m0_we;
                        s_adr_q <= pick ? m1_adr : m0_adr;
                        s_dat_q <= pick ? m1_dat : m0_dat;
                        s_sel_q <= pick ? m1_sel : m0_sel;
                        s_stb_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (xfer_end) begin
                        s_stb_q        <= 1'b0;
                        stale_q[gnt_q] <= 1'b1;
                        prio_q         <= ~gnt_q;
                        state_q        <= ST_DONE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    s_stb_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2: tests push expected slave cycles and master
// responses; monitors pop and compare them as the DUT produces them.
module tb_wb_arbiter2;

    localparam int TMO = 4;

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } req_t;

    typedef struct {
        int          m;
        logic        err;
        int          cyc;
        logic [31:0] rdat;
    } rsp_t;

    logic        clk;
    logic        rst_ni;
    logic        mst_stb [2];
    logic        mst_we  [2];
    logic [31:0] mst_adr [2];
    logic [31:0] mst_dat [2];
    logic [3:0]  mst_sel [2];
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [1:0]  mack, merr;
    logic [31:0] m_dat;
    logic        s_stb, s_we;
    logic [31:0] s_adr, s_dat;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_i;
    logic        s_ack;
    logic        gnt;

    logic        slave_ack;
    logic        stray_ack;
    logic [31:0] slave_rdat;
    int          ack_dly_m [2];

    req_t exp_req [$];
    rsp_t exp_rsp [$];
    int   n_cmp;
    int   n_mis;
    int   n_start;

    assign mack    = {m1_ack, m0_ack};
    assign merr    = {m1_err, m0_err};
    assign s_ack   = slave_ack | stray_ack;
    assign s_dat_i = slave_rdat;

    wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .m0_stb  (mst_stb[0]),
        .m0_we   (mst_we[0]),
        .m0_adr  (mst_adr[0]),
        .m0_dat  (mst_dat[0]),
        .m0_sel  (mst_sel[0]),
        .m0_ack  (m0_ack),
        .m0_err  (m0_err),
        .m1_stb  (mst_stb[1]),
        .m1_we   (mst_we[1]),
        .m1_adr  (mst_adr[1]),
        .m1_dat  (mst_dat[1]),
        .m1_sel  (mst_sel[1]),
        .m1_ack  (m1_ack),
        .m1_err  (m1_err),
        .m_dat   (m_dat),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_dat   (s_dat),
        .s_sel   (s_sel),
        .s_dat_i (s_dat_i),
        .s_ack   (s_ack),
        .gnt     (gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input int m, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        req_t r;
        r.m = m; r.we = we; r.adr = adr; r.dat = dat; r.sel = sel;
        exp_req.push_back(r);
    endtask

    task automatic push_rsp(input int m, input logic err, input int cyc, input logic [31:0] rdat);
        rsp_t p;
        p.m = m; p.err = err; p.cyc = cyc; p.rdat = rdat;
        exp_rsp.push_back(p);
    endtask

    task automatic drive_m(input int m, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
        mst_we[m]  = we;
        mst_adr[m] = adr;
        mst_dat[m] = dat;
        mst_sel[m] = sel;
        mst_stb[m] = 1'b1;
    endtask

    task automatic wait_done(input int m);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mack[m] || merr[m]) return;
        end
        chk("wait_done_bound", 96'(0), 96'(1));
    endtask

    task automatic wait_any();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((mack | merr) != 2'b00) return;
        end
        chk("wait_any_bound", 96'(0), 96'(1));
    endtask

    // raise strobe, wait for ack/err, keep strobe up 'hold' extra cycles, drop it
    task automatic xfer(input int m, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input int hold);
        @(posedge clk); #1;
        drive_m(m, we, adr, dat, sel);
        wait_done(m);
        repeat (hold + 1) @(posedge clk);
        #1;
        mst_stb[m] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_ni     = 1'b0;
        mst_stb[0] = 1'b0;
        mst_stb[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    // behavioural slave: acks in BUSY cycle ack_dly_m[gnt] (0-based), never if negative
    initial begin
        int scyc;
        scyc      = 0;
        slave_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (s_stb) begin
                slave_ack = (ack_dly_m[gnt] >= 0) && (scyc == ack_dly_m[gnt]);
                scyc++;
            end else begin
                slave_ack = 1'b0;
                scyc      = 0;
            end
        end
    end

    initial begin
        req_t        r;
        rsp_t        p;
        logic        stb_prev;
        int          bcyc;
        int          gap;
        int          who;
        logic [68:0] cap;
        logic        resp_last;
        stb_prev  = 1'b0;
        bcyc      = 0;
        gap       = 99;
        cap       = '0;
        resp_last = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_last) begin
                chk("s_stb_drop", 96'(s_stb), 96'(0));
                resp_last = 1'b0;
            end
            if (s_stb && !stb_prev) begin
                n_start++;
                chk("idle_gap", 96'(gap >= 2), 96'(1));
                if (exp_req.size() == 0) begin
                    chk("unexp_stb", 96'(1), 96'(0));
                end else begin
                    r = exp_req.pop_front();
                    chk("gnt",   96'(gnt),   96'(r.m));
                    chk("s_we",  96'(s_we),  96'(r.we));
                    chk("s_adr", 96'(s_adr), 96'(r.adr));
                    chk("s_dat", 96'(s_dat), 96'(r.dat));
                    chk("s_sel", 96'(s_sel), 96'(r.sel));
                end
                cap  = {s_we, s_adr, s_dat, s_sel};
                bcyc = 0;
            end else if (s_stb) begin
                bcyc++;
                chk("s_hold", 96'({s_we, s_adr, s_dat, s_sel}), 96'(cap));
            end
            gap      = s_stb ? 0 : gap + 1;
            stb_prev = s_stb;
            if ((mack | merr) != 2'b00) begin
                resp_last = 1'b1;
                chk("resp_onehot", 96'($countones({mack, merr})), 96'(1));
                who = (mack[1] | merr[1]) ? 1 : 0;
                if (exp_rsp.size() == 0) begin
                    chk("unexp_resp", 96'({mack, merr}), 96'(0));
                end else begin
                    p = exp_rsp.pop_front();
                    chk("rsp_master", 96'(who),   96'(p.m));
                    chk("rsp_err",    96'(|merr), 96'(p.err));
                    chk("rsp_cycle",  96'(bcyc),  96'(p.cyc));
                    if (!p.err) chk("m_dat", 96'(m_dat), 96'(p.rdat));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    int s0;
    int t2_win [3] = '{0, 1, 0};

    initial begin
        n_cmp      = 0;
        n_mis      = 0;
        n_start    = 0;
        rst_ni     = 1'b1;
        stray_ack  = 1'b0;
        slave_rdat = '0;
        for (int m = 0; m < 2; m++) begin
            mst_stb[m]   = 1'b0;
            mst_we[m]    = 1'b0;
            mst_adr[m]   = '0;
            mst_dat[m]   = '0;
            mst_sel[m]   = '0;
            ack_dly_m[m] = 0;
        end
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_s_stb", 96'(s_stb), 96'(0));
        chk("rst_s_we",  96'(s_we),  96'(0));
        chk("rst_s_adr", 96'(s_adr), 96'(0));
        chk("rst_s_dat", 96'(s_dat), 96'(0));
        chk("rst_s_sel", 96'(s_sel), 96'(0));
        chk("rst_gnt",   96'(gnt),   96'(0));
        chk("rst_resp",  96'({mack, merr}), 96'(0));
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // T1: single read, slave acks in the third BUSY cycle, strobe held one extra cycle
        slave_rdat   = 32'hDEADBEEF;
        ack_dly_m[0] = 2;
        s0           = n_start;
        push_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
        push_rsp(0, 1'b0, 2, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive_m(0, 1'b0, 32'h100, 32'h0, 4'hF);
        @(negedge clk);
        chk("lat_pre", 96'(s_stb), 96'(0));
        @(negedge clk);
        chk("lat_post", 96'(s_stb), 96'(1));
        wait_done(0);
        repeat (2) @(posedge clk);
        #1 mst_stb[0] = 1'b0;
        repeat (6) @(posedge clk);
        chk("t1_one_stb", 96'(n_start - s0), 96'(1));

        // ack while idle must not reach a master
        @(posedge clk); #1 stray_ack = 1'b1;
        @(negedge clk);
        chk("stray_ack", 96'({mack, merr}), 96'(0));
        @(posedge clk); #1 stray_ack = 1'b0;

        // T2: simultaneous requests three times, both drop after the winner completes
        do_reset();
        ack_dly_m[0] = 0;
        ack_dly_m[1] = 0;
        slave_rdat   = 32'h2222_0002;
        for (int r = 0; r < 3; r++) begin
            push_req(t2_win[r], 1'b0, 32'h300 + 32'(r * 16 + t2_win[r]), 32'h0, 4'hF);
            push_rsp(t2_win[r], 1'b0, 0, 32'h2222_0002);
            @(posedge clk); #1;
            drive_m(0, 1'b0, 32'h300 + 32'(r * 16), 32'h0, 4'hF);
            drive_m(1, 1'b0, 32'h300 + 32'(r * 16 + 1), 32'h0, 4'hF);
            wait_any();
            @(posedge clk); #1;
            mst_stb[0] = 1'b0;
            mst_stb[1] = 1'b0;
        end

        // T3: m1 write while m0 waits; m1 changes its inputs mid-transfer
        ack_dly_m[1] = 2;
        ack_dly_m[0] = 1;
        slave_rdat   = 32'hCAFE_0003;
        push_req(1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
        push_req(0, 1'b0, 32'h104, 32'h0, 4'hF);
        push_rsp(1, 1'b0, 2, 32'hCAFE_0003);
        push_rsp(0, 1'b0, 1, 32'hCAFE_0003);
        fork
            xfer(1, 1'b1, 32'h200, 32'h12345678, 4'b0011, 0);
            begin
                @(posedge clk);
                xfer(0, 1'b0, 32'h104, 32'h0, 4'hF, 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                mst_we[1]  = 1'b0;
                mst_adr[1] = 32'hFFFF_0000;
                mst_dat[1] = 32'hFFFF_FFFF;
                mst_sel[1] = 4'b1100;
            end
        join

        // T4: slave never acks m0 -> err in 4th BUSY cycle, then m1 is served
        ack_dly_m[0] = -1;
        ack_dly_m[1] = 0;
        slave_rdat   = 32'h0BAD_F00D;
        push_req(0, 1'b0, 32'h400, 32'h0, 4'hF);
        push_req(1, 1'b0, 32'h500, 32'h0, 4'h3);
        push_rsp(0, 1'b1, TMO - 1, 32'h0);
        push_rsp(1, 1'b0, 0, 32'h0BAD_F00D);
        fork
            xfer(0, 1'b0, 32'h400, 32'h0, 4'hF, 0);
            begin
                repeat (2) @(posedge clk);
                xfer(1, 1'b0, 32'h500, 32'h0, 4'h3, 0);
            end
        join

        // T5: ack lands on the timeout cycle -> ack, no err
        ack_dly_m[0] = TMO - 1;
        slave_rdat   = 32'h55AA_0005;
        push_req(0, 1'b1, 32'h600, 32'hA5A5A5A5, 4'hF);
        push_rsp(0, 1'b0, TMO - 1, 32'h55AA_0005);
        xfer(0, 1'b1, 32'h600, 32'hA5A5A5A5, 4'hF, 0);

        // T7: m1 drops strobe mid-BUSY; ack still delivered, next request accepted
        ack_dly_m[1] = 2;
        slave_rdat   = 32'h7777_0007;
        push_req(1, 1'b0, 32'h700, 32'h0, 4'hF);
        push_rsp(1, 1'b0, 2, 32'h7777_0007);
        push_req(1, 1'b0, 32'h704, 32'h0, 4'hF);
        push_rsp(1, 1'b0, 2, 32'h7777_0007);
        @(posedge clk); #1;
        drive_m(1, 1'b0, 32'h700, 32'h0, 4'hF);
        repeat (2) @(posedge clk);
        #1 mst_stb[1] = 1'b0;
        wait_done(1);
        @(posedge clk);
        xfer(1, 1'b0, 32'h704, 32'h0, 4'hF, 0);

        // T6: async reset during m1's BUSY (prio was 1) -> everything cleared, prio back to 0
        ack_dly_m[0] = 0;
        ack_dly_m[1] = -1;
        slave_rdat   = 32'h6666_0006;
        push_req(0, 1'b0, 32'h800, 32'h0, 4'hF);
        push_rsp(0, 1'b0, 0, 32'h6666_0006);
        xfer(0, 1'b0, 32'h800, 32'h0, 4'hF, 0);
        push_req(1, 1'b1, 32'h900, 32'h99, 4'hF);
        @(posedge clk); #1;
        drive_m(1, 1'b1, 32'h900, 32'h99, 4'hF);
        repeat (3) @(posedge clk);
        #3 rst_ni = 1'b0;
        #1;
        chk("rst_async_stb",  96'(s_stb), 96'(0));
        chk("rst_async_gnt",  96'(gnt),   96'(0));
        chk("rst_async_resp", 96'({mack, merr}), 96'(0));
        mst_stb[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_stb", 96'(s_stb), 96'(0));
        chk("post_rst_gnt", 96'(gnt),   96'(0));
        ack_dly_m[1] = 0;
        push_req(0, 1'b0, 32'hA00, 32'h0, 4'hF);
        push_rsp(0, 1'b0, 0, 32'h6666_0006);
        @(posedge clk); #1;
        drive_m(0, 1'b0, 32'hA00, 32'h0, 4'hF);
        drive_m(1, 1'b0, 32'hA04, 32'h0, 4'hF);
        wait_any();
        @(posedge clk); #1;
        mst_stb[0] = 1'b0;
        mst_stb[1] = 1'b0;

        repeat (6) @(posedge clk);
        chk("sb_req_drain", 96'(exp_req.size()), 96'(0));
        chk("sb_rsp_drain", 96'(exp_rsp.size()), 96'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
